// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W0..W15 through a handshake, then expands
// W16..W63 from a 16-word sliding window. Emits one word per cycle on the falling clock edge.
module sha256_msg_sched (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] msg_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [31:0] w_out,
  output logic        w_valid,
  output logic [5:0]  round,
  output logic        control,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [15:0][31:0]   win_q, win_d;
  logic [31:0]         w_out_q, w_out_d;
  logic                w_valid_q, w_valid_d;
  logic [5:0]          round_q, round_d;
  logic                control_q, control_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                shift_en;
  logic [31:0]         shift_word;
  logic [31:0]         expand_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win_q[0] is W[t-16], win_q[15] is W[t-1]
  assign expand_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  assign win_d       = shift_en ? {shift_word, win_q[15:1]} : win_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_out_d    = w_out_q;
    round_d    = round_q;
    w_valid_d  = 1'b0;
    control_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_en   = 1'b0;
    shift_word = expand_word;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          cnt_d     = 6'd0;
          control_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (msg_valid) begin
          shift_en   = 1'b1;
          shift_word = msg_in;
          w_out_d    = msg_in;
          round_d    = cnt_q;
          w_valid_d  = 1'b1;
          cnt_d      = cnt_q + 6'd1;
          if (cnt_q == 6'd15) state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        // cnt wrapped to 0 on the W63 edge, so zero here means the block is finished
        if (cnt_q == 6'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          shift_en  = 1'b1;
          w_out_d   = expand_word;
          round_d   = cnt_q;
          w_valid_d = 1'b1;
          cnt_d     = cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      win_q     <= '0;
      w_out_q   <= 32'd0;
      w_valid_q <= 1'b0;
      round_q   <= 6'd0;
      control_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      w_out_q   <= w_out_d;
      w_valid_q <= w_valid_d;
      round_q   <= round_d;
      control_q <= control_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign msg_ready = (state_q == ST_LOAD);
  assign w_out     = w_out_q;
  assign w_valid   = w_valid_q;
  assign round     = round_q;
  assign control   = control_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
